lbp_host: RTL and testbench

LBP_HOST -- requirements
Module: lbp_host

---
 rtl/lbp_host.sv | 211 +++++++++++++++++++++
 tb/tb_lbp_host.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_host.sv
// lbp_host: frame sequencer between an LBP engine, an asynchronous image ROM and a result RAM.
// Pixel reads pass straight through; engine results are filtered to interior pixels, then the border is zeroed.
module lbp_host #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        gray_ready,
  input  logic        gray_req,
  input  logic [13:0] gray_addr,
  output logic [7:0]  gray_data,
  output logic [13:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic [13:0] lbp_addr,
  input  logic        lbp_valid,
  input  logic [7:0]  lbp_data,
  input  logic        finish,
  output logic        res_we,
  output logic [13:0] res_addr,
  output logic [7:0]  res_data,
  output logic        busy,
  output logic        done,
  output logic [13:0] wr_count,
  output logic        err_border,
  output logic        err_timeout,
  output logic        err_count
);

  localparam int          WD_W         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [13:0] FRAME_WRITES = 14'd15876;
  localparam logic [13:0] WR_MAX       = 14'h3FFF;
  localparam logic [6:0]  EDGE_HI      = 7'd127;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_RUN,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [13:0]     wr_count_q, wr_count_d;
  logic            err_border_q, err_border_d;
  logic            err_timeout_q, err_timeout_d;
  logic            err_count_q, err_count_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [6:0]      clr_row_q, clr_row_d;
  logic [6:0]      clr_col_q, clr_col_d;
  logic            res_we_q, res_we_d;
  logic [13:0]     res_addr_q, res_addr_d;
  logic [7:0]      res_data_q, res_data_d;

  logic [6:0]      lbp_row;
  logic [6:0]      lbp_col;
  logic            lbp_border;
  logic [13:0]     wr_inc;
  logic            wd_expire;
  logic            clr_last;
  logic [6:0]      clr_row_nx;
  logic [6:0]      clr_col_nx;

  assign rom_addr  = gray_addr;
  assign gray_data = rom_data;

  assign lbp_row    = lbp_addr[13:7];
  assign lbp_col    = lbp_addr[6:0];
  assign lbp_border = (lbp_row == 7'd0) || (lbp_row == EDGE_HI) ||
                      (lbp_col == 7'd0) || (lbp_col == EDGE_HI);

  assign wr_inc    = (wr_count_q == WR_MAX) ? WR_MAX : wr_count_q + 14'd1;
  assign wd_expire = (wd_q == WD_W'(TIMEOUT_CYC - 1));
  assign clr_last  = (clr_row_q == EDGE_HI) && (clr_col_q == EDGE_HI);

  // Border walk: full top/bottom rows, and only the two edge columns of middle rows.
  always_comb begin
    clr_row_nx = clr_row_q;
    clr_col_nx = clr_col_q;
    if ((clr_row_q == 7'd0) || (clr_row_q == EDGE_HI)) begin
      if (clr_col_q == EDGE_HI) begin
        clr_row_nx = clr_row_q + 7'd1;
        clr_col_nx = 7'd0;
      end else begin
        clr_col_nx = clr_col_q + 7'd1;
      end
    end else begin
      if (clr_col_q == 7'd0) begin
        clr_col_nx = EDGE_HI;
      end else begin
        clr_row_nx = clr_row_q + 7'd1;
        clr_col_nx = 7'd0;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_count_d    = wr_count_q;
    err_border_d  = err_border_q;
    err_timeout_d = err_timeout_q;
    err_count_d   = err_count_q;
    wd_d          = wd_q;
    clr_row_d     = clr_row_q;
    clr_col_d     = clr_col_q;
    res_we_d      = 1'b0;
    res_addr_d    = res_addr_q;
    res_data_d    = res_data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_READY;
          wr_count_d    = '0;
          err_border_d  = 1'b0;
          err_timeout_d = 1'b0;
          err_count_d   = 1'b0;
          wd_d          = '0;
          clr_row_d     = '0;
          clr_col_d     = '0;
        end
      end

      S_READY: begin
        if (gray_req) begin
          state_d = S_RUN;
          wd_d    = '0;
        end
      end

      S_RUN: begin
        wd_d = lbp_valid ? '0 : wd_q + WD_W'(1);
        if (lbp_valid) begin
          if (lbp_border) begin
            err_border_d = 1'b1;
          end else begin
            res_we_d   = 1'b1;
            res_addr_d = lbp_addr;
            res_data_d = lbp_data;
            wr_count_d = wr_inc;
          end
        end
        // A same-cycle result is already folded into wr_count_d before the frame count is judged.
        if (finish) begin
          state_d = S_CLEAR;
          if (wr_count_d != FRAME_WRITES) begin
            err_count_d = 1'b1;
          end
        end else if (!lbp_valid && wd_expire) begin
          state_d       = S_CLEAR;
          err_timeout_d = 1'b1;
        end
      end

      S_CLEAR: begin
        res_we_d   = 1'b1;
        res_addr_d = {clr_row_q, clr_col_q};
        res_data_d = 8'd0;
        clr_row_d  = clr_row_nx;
        clr_col_d  = clr_col_nx;
        if (clr_last) begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_count_q    <= '0;
      err_border_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      err_count_q   <= 1'b0;
      wd_q          <= '0;
      clr_row_q     <= '0;
      clr_col_q     <= '0;
      res_we_q      <= 1'b0;
      res_addr_q    <= '0;
      res_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_count_q    <= wr_count_d;
      err_border_q  <= err_border_d;
      err_timeout_q <= err_timeout_d;
      err_count_q   <= err_count_d;
      wd_q          <= wd_d;
      clr_row_q     <= clr_row_d;
      clr_col_q     <= clr_col_d;
      res_we_q      <= res_we_d;
      res_addr_q    <= res_addr_d;
      res_data_q    <= res_data_d;
    end
  end

  assign gray_ready  = (state_q == S_READY) || (state_q == S_RUN);
  assign busy        = (state_q == S_READY) || (state_q == S_RUN) || (state_q == S_CLEAR);
  assign done        = (state_q == S_DONE);
  assign res_we      = res_we_q;
  assign res_addr    = res_addr_q;
  assign res_data    = res_data_q;
  assign wr_count    = wr_count_q;
  assign err_border  = err_border_q;
  assign err_timeout = err_timeout_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_lbp_host.sv
// tb_lbp_host: randomized frames against a transaction-level model of lbp_host.
// Expected result-RAM writes are kept as a timed queue; status outputs are predicted from a frame phase.
module tb_lbp_host;

  localparam int TMO          = 64;
  localparam int FRAME_WRITES = 15876;
  localparam int WR_SAT       = 16383;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        gray_req = 1'b0;
  logic [13:0] gray_addr = '0;
  logic        gray_ready;
  logic [7:0]  gray_data;
  logic [13:0] rom_addr;
  logic [7:0]  rom_data;
  logic [13:0] lbp_addr = '0;
  logic        lbp_valid = 1'b0;
  logic [7:0]  lbp_data = '0;
  logic        finish = 1'b0;
  logic        res_we;
  logic [13:0] res_addr;
  logic [7:0]  res_data;
  logic        busy;
  logic        done;
  logic [13:0] wr_count;
  logic        err_border;
  logic        err_timeout;
  logic        err_count;

  logic [7:0]  rom [16384];

  int tests_run = 0;
  int tests_failed = 0;

  lbp_host #(.TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .gray_ready  (gray_ready),
    .gray_req    (gray_req),
    .gray_addr   (gray_addr),
    .gray_data   (gray_data),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .lbp_addr    (lbp_addr),
    .lbp_valid   (lbp_valid),
    .lbp_data    (lbp_data),
    .finish      (finish),
    .res_we      (res_we),
    .res_addr    (res_addr),
    .res_data    (res_data),
    .busy        (busy),
    .done        (done),
    .wr_count    (wr_count),
    .err_border  (err_border),
    .err_timeout (err_timeout),
    .err_count   (err_count)
  );

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  // Behavioural model: frame phase, counters, and a queue of writes stamped with the cycle they must appear.
  typedef enum {M_IDLE, M_READY, M_RUN, M_CLEAR, M_DONE} model_phase_t;

  typedef struct {
    int          cyc;
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_t;

  model_phase_t m_phase = M_IDLE;
  int  cyc = 0;
  int  m_wr = 0;
  bit  m_eb = 1'b0;
  bit  m_et = 1'b0;
  bit  m_ec = 1'b0;
  int  m_idle = 0;
  int  m_clear_end = 0;
  wr_t exp_q[$];

  function automatic bit is_border(input logic [13:0] a);
    int r = int'(a) / 128;
    int c = int'(a) % 128;
    return (r == 0) || (r == 127) || (c == 0) || (c == 127);
  endfunction

  function automatic logic [13:0] rand_interior();
    int r = $urandom_range(1, 126);
    int c = $urandom_range(1, 126);
    return 14'(r * 128 + c);
  endfunction

  // Border zeroing is raster order restricted to border pixels, one write per cycle after the trigger.
  task automatic enter_clear();
    wr_t e;
    int  k = 0;
    for (int a = 0; a < 16384; a++) begin
      if (is_border(14'(a))) begin
        e.cyc  = cyc + 1 + k;
        e.addr = 14'(a);
        e.data = 8'h00;
        exp_q.push_back(e);
        k++;
      end
    end
    m_clear_end = cyc + k;
    m_phase     = M_CLEAR;
  endtask

  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        m_phase = M_IDLE;
        m_wr    = 0;
        m_eb    = 1'b0;
        m_et    = 1'b0;
        m_ec    = 1'b0;
        m_idle  = 0;
        exp_q.delete();
      end else begin
        case (m_phase)
          M_IDLE, M_DONE: begin
            if (start) begin
              m_phase = M_READY;
              m_wr    = 0;
              m_eb    = 1'b0;
              m_et    = 1'b0;
              m_ec    = 1'b0;
              m_idle  = 0;
            end
          end
          M_READY: begin
            if (gray_req) begin
              m_phase = M_RUN;
              m_idle  = 0;
            end
          end
          M_RUN: begin
            if (lbp_valid) begin
              m_idle = 0;
              if (is_border(lbp_addr)) begin
                m_eb = 1'b1;
              end else begin
                e.cyc  = cyc;
                e.addr = lbp_addr;
                e.data = lbp_data;
                exp_q.push_back(e);
                if (m_wr < WR_SAT) m_wr++;
              end
            end else begin
              m_idle++;
            end
            if (finish) begin
              if (m_wr != FRAME_WRITES) m_ec = 1'b1;
              enter_clear();
            end else if (m_idle >= TMO) begin
              m_et = 1'b1;
              enter_clear();
            end
          end
          M_CLEAR: begin
            if (cyc == m_clear_end) m_phase = M_DONE;
          end
          default: m_phase = M_IDLE;
        endcase
      end
    end
  end

  // Every cycle compare: the write strobe against the timed queue, plus status, counters and the read path.
  task automatic checkOutput();
    wr_t e;
    bit  exp_we;
    bit  exp_ready;
    bit  exp_busy;
    bit  exp_done;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL missed_write cycle %0d: addr 0x%0h data 0x%0h never written", exp_q[0].cyc,
               exp_q[0].addr, exp_q[0].data);
      void'(exp_q.pop_front());
    end
    exp_we = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    tests_run++;
    if (res_we !== exp_we) begin
      tests_failed++;
      $display("[TB] FAIL res_we cycle %0d: got %b, expected %b", cyc, res_we, exp_we);
    end else if (exp_we) begin
      e = exp_q.pop_front();
      tests_run++;
      if (res_addr !== e.addr || res_data !== e.data) begin
        tests_failed++;
        $display("[TB] FAIL write_payload cycle %0d: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                 cyc, res_addr, res_data, e.addr, e.data);
      end
    end
    exp_ready = (m_phase == M_READY) || (m_phase == M_RUN);
    exp_busy  = exp_ready || (m_phase == M_CLEAR);
    exp_done  = (m_phase == M_DONE);
    tests_run++;
    if ({gray_ready, busy, done, err_border, err_timeout, err_count} !==
        {exp_ready, exp_busy, exp_done, m_eb, m_et, m_ec}) begin
      tests_failed++;
      $display("[TB] FAIL status cycle %0d: got rdy/busy/done/eb/et/ec %b%b%b%b%b%b, expected %b%b%b%b%b%b",
               cyc, gray_ready, busy, done, err_border, err_timeout, err_count,
               exp_ready, exp_busy, exp_done, m_eb, m_et, m_ec);
    end
    tests_run++;
    if (wr_count !== 14'(m_wr)) begin
      tests_failed++;
      $display("[TB] FAIL wr_count cycle %0d: got %0d, expected %0d", cyc, wr_count, m_wr);
    end
    tests_run++;
    if (rom_addr !== gray_addr || gray_data !== rom[gray_addr]) begin
      tests_failed++;
      $display("[TB] FAIL read_path cycle %0d: got rom_addr 0x%0h gray_data 0x%0h, expected 0x%0h 0x%0h",
               cyc, rom_addr, gray_data, gray_addr, rom[gray_addr]);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) checkOutput();
    end
  end

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_lit({tag, "_gray_ready"}, 32'(gray_ready), 32'd0);
    check_lit({tag, "_res_we"}, 32'(res_we), 32'd0);
    check_lit({tag, "_res_addr"}, 32'(res_addr), 32'd0);
    check_lit({tag, "_res_data"}, 32'(res_data), 32'd0);
    check_lit({tag, "_busy"}, 32'(busy), 32'd0);
    check_lit({tag, "_done"}, 32'(done), 32'd0);
    check_lit({tag, "_wr_count"}, 32'(wr_count), 32'd0);
    check_lit({tag, "_err_border"}, 32'(err_border), 32'd0);
    check_lit({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
    check_lit({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  // Drive one cycle of inputs, then return just after the edge that samples them.
  task automatic applyStimulus(input bit s, input bit g, input bit v, input logic [13:0] a,
                               input logic [7:0] d, input bit f);
    start     = s;
    gray_req  = g;
    lbp_valid = v;
    lbp_addr  = a;
    lbp_data  = d;
    finish    = f;
    gray_addr = 14'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 14'd0, 8'd0, 1'b0);
  endtask

  task automatic wait_done(input string name, input int bound);
    int  n = 0;
    bit  s;
    while (!done && n < bound) begin
      s = busy && ($urandom_range(0, 15) == 0);
      applyStimulus(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 14'($urandom), 8'($urandom), 1'b0);
      n++;
    end
    check_lit({name, "_done_within_bound"}, 32'(done), 32'd1);
  endtask

  task automatic begin_frame();
    applyStimulus(1'b1, 1'b0, 1'b0, 14'd0, 8'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 14'd0, 8'd0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_time_limit: got no end of run, expected $finish before limit");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    for (int i = 0; i < 16384; i++) rom[i] = 8'($urandom);
    rom[14'h0081] = 8'h5A;

    reset = 1'b1;
    repeat (3) idle_cycle();
    check_reset_values("reset");
    reset = 1'b0;
    idle_cycle();

    gray_addr = 14'h0081;
    #1;
    check_lit("read_0x0081", 32'(gray_data), 32'h5A);

    $display("[TB] frame A: border write, short frame, result with finish");
    applyStimulus(1'b1, 1'b0, 1'b0, 14'd0, 8'd0, 1'b0);
    check_lit("ready_busy", 32'(busy), 32'd1);
    check_lit("ready_gray_ready", 32'(gray_ready), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 14'd0, 8'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 14'h0000, 8'hEE, 1'b0);
    check_lit("border_err_border", 32'(err_border), 32'd1);
    check_lit("border_res_we", 32'(res_we), 32'd0);
    check_lit("border_wr_count", 32'(wr_count), 32'd0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 1'b1, rand_interior(), 8'($urandom), 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 14'h0101, 8'hC3, 1'b1);
    check_lit("fin_res_we", 32'(res_we), 32'd1);
    check_lit("fin_res_addr", 32'(res_addr), 32'h0101);
    check_lit("fin_res_data", 32'(res_data), 32'hC3);
    check_lit("fin_wr_count", 32'(wr_count), 32'd10);
    check_lit("fin_err_count", 32'(err_count), 32'd1);
    idle_cycle();
    check_lit("clear0_res_we", 32'(res_we), 32'd1);
    check_lit("clear0_res_addr", 32'(res_addr), 32'h0000);
    check_lit("clear0_res_data", 32'(res_data), 32'h00);
    wait_done("frame_a", 600);

    $display("[TB] frame B: watchdog expiry");
    begin_frame();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, rand_interior(), 8'($urandom), 1'b0);
    repeat (TMO - 1) idle_cycle();
    check_lit("pre_timeout_busy_run", 32'(gray_ready), 32'd1);
    idle_cycle();
    check_lit("timeout_err_timeout", 32'(err_timeout), 32'd1);
    check_lit("timeout_gray_ready", 32'(gray_ready), 32'd0);
    wait_done("frame_b", 600);
    check_lit("timeout_err_count", 32'(err_count), 32'd0);

    $display("[TB] frame C: reset during border clear");
    begin_frame();
    applyStimulus(1'b0, 1'b0, 1'b0, 14'd0, 8'd0, 1'b1);
    repeat (100) idle_cycle();
    reset = 1'b1;
    idle_cycle();
    check_reset_values("mid_clear_reset");
    reset = 1'b0;
    idle_cycle();

    $display("[TB] randomized frames");
    for (int f = 0; f < 6; f++) begin
      int n;
      applyStimulus(1'b1, 1'b0, 1'b0, 14'd0, 8'd0, 1'b0);
      repeat ($urandom_range(0, 3)) applyStimulus(1'b0, 1'b0, 1'b1, rand_interior(), 8'($urandom), 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 14'd0, 8'd0, 1'b0);
      n = $urandom_range(8, 40);
      for (int i = 0; i < n; i++) begin
        bit          v;
        bit          s;
        logic [13:0] a;
        if (f == 2 && i == n / 2) repeat (TMO + 2) idle_cycle();
        v = ($urandom_range(0, 2) != 0);
        a = ($urandom_range(0, 7) == 0) ? 14'($urandom) : rand_interior();
        s = busy && ($urandom_range(0, 19) == 0);
        applyStimulus(s, 1'($urandom_range(0, 1)), v, a, 8'($urandom), (i == n - 1));
      end
      wait_done("random_frame", 700);
      repeat ($urandom_range(0, 4)) idle_cycle();
    end

    $display("[TB] full frame of interior writes");
    begin_frame();
    for (int r = 1; r <= 126; r++) begin
      for (int c = 1; c <= 126; c++) begin
        applyStimulus(1'b0, 1'b0, 1'b1, 14'(r * 128 + c), 8'($urandom), (r == 126 && c == 126));
      end
    end
    check_lit("full_wr_count", 32'(wr_count), 32'd15876);
    check_lit("full_err_count", 32'(err_count), 32'd0);
    check_lit("full_err_border", 32'(err_border), 32'd0);
    check_lit("full_err_timeout", 32'(err_timeout), 32'd0);
    wait_done("full_frame", 600);

    $display("[TB] wr_count saturation");
    begin_frame();
    for (int i = 0; i < 16400; i++) applyStimulus(1'b0, 1'b0, 1'b1, rand_interior(), 8'($urandom), 1'b0);
    check_lit("sat_wr_count", 32'(wr_count), 32'd16383);
    applyStimulus(1'b0, 1'b0, 1'b0, 14'd0, 8'd0, 1'b1);
    check_lit("sat_err_count", 32'(err_count), 32'd1);
    wait_done("sat_frame", 600);

    repeat (4) idle_cycle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
